mem_access_seq: RTL

// - Parametrised memory micro-sequencer: accepts one load/store request, optionally follows N pointer

---
 rtl/mem_access_seq_pkg.sv | 20 ++
 rtl/mem_access_seq_lane.sv | 33 +++
 rtl/mem_access_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared types and helpers for the memory access micro-sequencer.
// Holds the sequencer state encoding and the byte-lane one-hot helper.
package mem_access_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IND,
        RD,
        WR,
        RESP
    } mem_seq_state_t;

    // Widest lane mask the helper can produce; callers cast down to BYTES.
    localparam int unsigned MAX_BYTES = 64;

    function automatic logic [MAX_BYTES-1:0] lane_onehot(input int unsigned lsb);
        return MAX_BYTES'(1) << lsb;
    endfunction

endpackage

// File: rtl/mem_access_seq_lane.sv
// Combinational byte-lane helpers: address alignment, lane extract, byte replicate, byte enables.
// Ports: addr_i/rdata_i/wbyte_i in; aligned_o, lane_rdata_o, repl_o, be_o out.
module mem_byte_lane
    import mem_access_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    localparam int BYTES = DATA_W / 8,
    localparam int LSB_W = $clog2(BYTES)
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [7:0]        wbyte_i,
    output logic [ADDR_W-1:0] aligned_o,
    output logic [DATA_W-1:0] lane_rdata_o,
    output logic [DATA_W-1:0] repl_o,
    output logic [BYTES-1:0]  be_o
);

    logic [LSB_W-1:0] lsb;

    assign lsb = addr_i[LSB_W-1:0];

    assign aligned_o = {addr_i[ADDR_W-1:LSB_W], LSB_W'(0)};

    // Shift the addressed lane down to bit 0, keep 8 bits, zero-extend.
    assign lane_rdata_o = DATA_W'(8'(rdata_i >> {lsb, 3'b000}));

    assign repl_o = {BYTES{wbyte_i}};

    assign be_o = BYTES'(lane_onehot(32'(lsb)));

endmodule

// File: rtl/mem_access_seq.sv
// Memory micro-sequencer: one load/store per request, optional pointer indirection,
// word/byte access with lane masking, per-beat timeout, one-cycle response pulse.
// Ports: clk_i, reset_i (sync, high); req_* request side; resp_* response side;
// mem_* memory port (strobes held until mem_resp_i).
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MAX_IND = 1,
    parameter int TIMEOUT = 255,
    localparam int BYTES  = DATA_W / 8,
    localparam int IND_W  = (MAX_IND > 0) ? $clog2(MAX_IND + 1) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic              req_byte_i,
    input  logic [IND_W-1:0]  req_ind_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [BYTES-1:0]  mem_byte_enable_o,
    input  logic              mem_resp_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    mem_seq_state_t    state_q, state_d;
    logic [IND_W-1:0]  ind_q, ind_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] aligned;
    logic [DATA_W-1:0] lane_rdata;
    logic [DATA_W-1:0] repl;
    logic [BYTES-1:0]  be;
    logic [IND_W-1:0]  ind_clamp;
    logic              tmo;

    mem_byte_lane #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_lane (
        .addr_i       (ptr_q),
        .rdata_i      (mem_rdata_i),
        .wbyte_i      (wdata_q[7:0]),
        .aligned_o    (aligned),
        .lane_rdata_o (lane_rdata),
        .repl_o       (repl),
        .be_o         (be)
    );

    assign ind_clamp = (req_ind_i > IND_W'(MAX_IND)) ? IND_W'(MAX_IND) : req_ind_i;

    // Last allowed wait cycle of a beat with no completion; mem_resp wins a tie.
    assign tmo = TMO_EN && (cnt_q == CNT_LAST) && !mem_resp_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ind_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ind_q   <= ind_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            write_q <= write_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ind_d   = ind_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        write_d = write_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ind_d   = ind_clamp;
                    ptr_d   = req_addr_i;
                    write_d = req_write_i;
                    byte_d  = req_byte_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (ind_clamp != '0) begin
                        state_d = IND;
                    end else if (req_write_i) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            IND: begin
                if (mem_resp_i) begin
                    ptr_d = ADDR_W'(mem_rdata_i);
                    ind_d = ind_q - IND_W'(1);
                    cnt_d = '0;
                    if (ind_q == IND_W'(1)) begin
                        state_d = write_q ? WR : RD;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD: begin
                if (mem_resp_i) begin
                    rdata_d = byte_q ? lane_rdata : mem_rdata_i;
                    state_d = RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                if (mem_resp_i) begin
                    state_d = RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o       = (state_q == IDLE);
        resp_valid_o      = (state_q == RESP);
        resp_err_o        = (state_q == RESP) && err_q;
        resp_rdata_o      = (state_q == RESP) ? rdata_q : '0;
        mem_read_o        = (state_q == IND) || (state_q == RD);
        mem_write_o       = (state_q == WR);
        mem_address_o     = aligned;
        mem_wdata_o       = byte_q ? repl : wdata_q;
        mem_byte_enable_o = '1;
        // Only the final byte beat uses the unaligned address; pointers are word reads.
        if (byte_q && ((state_q == RD) || (state_q == WR))) begin
            mem_address_o = ptr_q;
        end
        if (byte_q && (state_q == WR)) begin
            mem_byte_enable_o = be;
        end
    end

endmodule
